// File: rtl/ps2_keyboard_rx_if.sv
// Signal bundle for the PS/2 keyboard receiver: raw pins towards the receiver,
// decoded scan codes, error strobes and held-key action levels back out.
interface ps2_keyboard_rx_if #(
    parameter int N_ACTIONS = 6
);
    logic                 ps2_clk;
    logic                 ps2_data;
    logic [N_ACTIONS-1:0] acoes;
    logic [7:0]           scan_code;
    logic                 scan_ext;
    logic                 scan_break;
    logic                 scan_valid;
    logic                 parity_err;
    logic                 frame_err;

    // master: the receiver itself; slave: keyboard pins plus the consuming logic
    modport master (
        input  ps2_clk, ps2_data,
        output acoes, scan_code, scan_ext, scan_break, scan_valid, parity_err, frame_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  acoes, scan_code, scan_ext, scan_break, scan_valid, parity_err, frame_err
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// System-clock PS/2 keyboard receiver: synchronise and filter the pins, deframe 11-bit
// frames, decode E0/F0 prefixes and drive held-key action levels through a keymap.
module ps2_keyboard_rx #(
    parameter int                      N_ACTIONS  = 6,
    parameter int                      FILTER_LEN = 8,
    parameter int                      TIMEOUT    = 50000,
    parameter logic [N_ACTIONS*18-1:0] KEYMAP     = {
        9'h05A, 9'h05A,   // 5: enter
        9'h029, 9'h029,   // 4: space
        9'h174, 9'h023,   // 3: right / D
        9'h172, 9'h01B,   // 2: down  / S
        9'h16B, 9'h01C,   // 1: left  / A
        9'h175, 9'h01D    // 0: up    / W
    }
) (
    input  logic              clk,
    input  logic              reset,
    ps2_keyboard_rx_if.master io_bus
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic                 r_clk_meta;
    logic                 r_clk_sync;
    logic                 r_data_meta;
    logic                 r_data_sync;
    logic                 r_clk_filt;
    logic [FW-1:0]        r_filt_cnt;
    logic                 r_fall_edge;
    logic                 w_filt_flip;

    state_t               r_state;
    state_t               w_state_next;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic                 r_parity;
    logic [TW-1:0]        r_idle_cnt;
    logic                 w_idle_expired;

    logic                 w_start;
    logic                 w_shift_en;
    logic                 w_parity_en;
    logic                 w_stop_seen;
    logic                 w_timeout;
    logic                 w_frame_bad;
    logic                 w_parity_bad;
    logic                 w_frame_good;

    logic                 r_ext;
    logic                 r_brk;
    logic [N_ACTIONS-1:0] r_acoes;
    logic [7:0]           r_scan_code;
    logic                 r_scan_ext;
    logic                 r_scan_break;
    logic                 r_scan_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;

    // Idle PS/2 lines sit high, so the synchronisers reset to 1 to avoid a false falling edge.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= io_bus.ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_data_meta <= io_bus.ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    assign w_filt_flip = (r_clk_sync != r_clk_filt) && (r_filt_cnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_filt  <= 1'b1;
            r_filt_cnt  <= '0;
            r_fall_edge <= 1'b0;
        end else begin
            r_fall_edge <= w_filt_flip & r_clk_filt;
            if (r_clk_sync == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (w_filt_flip) begin
                r_clk_filt <= r_clk_sync;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    // Inter-bit watchdog: only runs while a frame is open and restarts on every falling edge.
    assign w_idle_expired = (r_idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || r_state == S_IDLE || r_fall_edge) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_parity_en  = 1'b0;
        w_stop_seen  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_fall_edge && !r_data_sync) begin
                    w_start      = 1'b1;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (r_fall_edge) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_PARITY;
                    end
                end else if (w_idle_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_PARITY: begin
                if (r_fall_edge) begin
                    w_parity_en  = 1'b1;
                    w_state_next = S_STOP;
                end else if (w_idle_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_STOP: begin
                if (r_fall_edge) begin
                    w_stop_seen  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_idle_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Odd parity: data plus parity bit must carry an odd number of ones.
    always_comb begin
        w_frame_bad  = w_timeout | (w_stop_seen & ~r_data_sync);
        w_parity_bad = w_stop_seen & r_data_sync & ~(^{r_shift, r_parity});
        w_frame_good = w_stop_seen & r_data_sync & (^{r_shift, r_parity});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {r_data_sync, r_shift[7:1]};
            end
            if (w_parity_en) begin
                r_parity <= r_data_sync;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_acoes      <= '0;
            r_scan_code  <= '0;
            r_scan_ext   <= 1'b0;
            r_scan_break <= 1'b0;
            r_scan_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_scan_valid <= 1'b0;
            r_parity_err <= w_parity_bad;
            r_frame_err  <= w_frame_bad;
            if (w_frame_bad || w_parity_bad) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_frame_good) begin
                for (int i = 0; i < N_ACTIONS; i++) begin
                    if ({r_ext, r_shift} == KEYMAP[18*i +: 9] ||
                        {r_ext, r_shift} == KEYMAP[18*i+9 +: 9]) begin
                        r_acoes[i] <= ~r_brk;
                    end
                end
                if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_scan_code  <= r_shift;
                    r_scan_ext   <= r_ext;
                    r_scan_break <= r_brk;
                    r_scan_valid <= 1'b1;
                    r_ext        <= 1'b0;
                    r_brk        <= 1'b0;
                end
            end
        end
    end

    assign io_bus.acoes      = r_acoes;
    assign io_bus.scan_code  = r_scan_code;
    assign io_bus.scan_ext   = r_scan_ext;
    assign io_bus.scan_break = r_scan_break;
    assign io_bus.scan_valid = r_scan_valid;
    assign io_bus.parity_err = r_parity_err;
    assign io_bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed scenarios plus randomized key traffic
// compared against a frame-level reference model with a key-to-action lookup table.
module tb_ps2_keyboard_rx;

    localparam int N_ACT = 6;
    localparam int FILT  = 8;
    localparam int TMO   = 2000;
    localparam int HALF  = 16;
    localparam int GAP   = 60;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ps2_keyboard_rx_if #(.N_ACTIONS(N_ACT)) bus ();

    ps2_keyboard_rx #(
        .N_ACTIONS (N_ACT),
        .FILTER_LEN(FILT),
        .TIMEOUT   (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Pulse tallies seen on the outputs; a pulse longer than one cycle inflates its tally.
    int n_scan = 0;
    int n_perr = 0;
    int n_ferr = 0;

    always @(negedge clk) begin
        if (bus.scan_valid === 1'b1) n_scan++;
        if (bus.parity_err === 1'b1) n_perr++;
        if (bus.frame_err === 1'b1)  n_ferr++;
    end

    // Reference model state
    logic [N_ACT-1:0] key_act [int];
    logic [8:0]       keys [12];
    int               exp_scan = 0;
    int               exp_perr = 0;
    int               exp_ferr = 0;
    logic [7:0]       exp_code = 8'h00;
    logic             exp_ext  = 1'b0;
    logic             exp_brk  = 1'b0;
    logic [N_ACT-1:0] exp_acoes = '0;
    logic             m_ext = 1'b0;
    logic             m_brk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_nscan"}, n_scan, exp_scan);
        check({tag, "_nperr"}, n_perr, exp_perr);
        check({tag, "_nferr"}, n_ferr, exp_ferr);
        check({tag, "_acoes"}, 32'(bus.acoes), 32'(exp_acoes));
        check({tag, "_code"},  32'(bus.scan_code), 32'(exp_code));
        check({tag, "_ext"},   32'(bus.scan_ext), 32'(exp_ext));
        check({tag, "_brk"},   32'(bus.scan_break), 32'(exp_brk));
    endtask

    task automatic model_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        int k;
        if (bad_stop) begin
            exp_ferr++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (bad_par) begin
            exp_perr++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            k = {m_ext, code};
            if (key_act.exists(k)) begin
                exp_acoes = m_brk ? (exp_acoes & ~key_act[k]) : (exp_acoes | key_act[k]);
            end
            if (code == 8'hE0) begin
                m_ext = 1'b1;
            end else if (code == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                exp_scan++;
                exp_code = code;
                exp_ext  = m_ext;
                exp_brk  = m_brk;
                m_ext    = 1'b0;
                m_brk    = 1'b0;
            end
        end
    endtask

    task automatic model_abort();
        exp_ferr++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        bus.ps2_data = b;
        repeat (HALF / 2) @(negedge clk);
        if (glitch) begin
            bus.ps2_clk = 1'b0;
            @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        repeat (HALF / 2) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                             input int nbits, input bit glitch);
        logic [10:0] f;
        f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
        bus.ps2_data = 1'b1;
    endtask

    task automatic xmit(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                        input bit glitch, input string tag);
        send_bits(code, bad_par, bad_stop, 11, glitch);
        repeat (GAP) @(negedge clk);
        model_frame(code, bad_par, bad_stop);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_acoes = '0;
        exp_code  = 8'h00;
        exp_ext   = 1'b0;
        exp_brk   = 1'b0;
        m_ext     = 1'b0;
        m_brk     = 1'b0;
    endtask

    initial begin
        int         sel;
        logic [8:0] k;
        logic [7:0] rb;

        keys = '{9'h01D, 9'h175, 9'h01C, 9'h16B, 9'h01B, 9'h172,
                 9'h023, 9'h174, 9'h029, 9'h029, 9'h05A, 9'h05A};
        for (int i = 0; i < 12; i++) begin
            if (key_act.exists(int'(keys[i]))) key_act[int'(keys[i])] |= N_ACT'(1) << (i / 2);
            else key_act[int'(keys[i])] = N_ACT'(1) << (i / 2);
        end

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset        = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        check("rst_acoes", 32'(bus.acoes), 32'd0);
        check("rst_valid", 32'(bus.scan_valid), 32'd0);
        check("rst_perr",  32'(bus.parity_err), 32'd0);
        check("rst_ferr",  32'(bus.frame_err), 32'd0);
        check_all("rst");

        // Plain make code
        xmit(8'h1C, 0, 0, 0, "t1");
        check("t1_acoes_lit", 32'(bus.acoes), 32'b000010);

        // Extended make then extended break of the same key
        xmit(8'hE0, 0, 0, 0, "t2a");
        xmit(8'h75, 0, 0, 0, "t2b");
        check("t2_up_held", 32'(bus.acoes[0]), 32'd1);
        xmit(8'hE0, 0, 0, 0, "t2c");
        xmit(8'hF0, 0, 0, 0, "t2d");
        xmit(8'h75, 0, 0, 0, "t2e");
        check("t2_up_released", 32'(bus.acoes[0]), 32'd0);
        check("t2_brk", 32'(bus.scan_break), 32'd1);

        // Parity error then the same key cleanly
        xmit(8'h29, 1, 0, 0, "t3a");
        xmit(8'h29, 0, 0, 0, "t3b");
        check("t3_space", 32'(bus.acoes[4]), 32'd1);

        // Truncated frame runs into the inter-bit timeout
        send_bits(8'h5A, 0, 0, 5, 0);
        repeat (TMO + 200) @(negedge clk);
        model_abort();
        check_all("t4a");
        xmit(8'h5A, 0, 0, 0, "t4b");
        check("t4_enter", 32'(bus.acoes[5]), 32'd1);

        // Short clock glitches inside every high phase
        xmit(8'h23, 0, 0, 1, "t5");
        check("t5_d", 32'(bus.acoes[3]), 32'd1);

        // Reset in the middle of a frame
        send_bits(8'h1B, 0, 0, 4, 0);
        do_reset();
        check_all("t6a");
        repeat (GAP) @(negedge clk);
        check_all("t6b");
        xmit(8'h1B, 0, 0, 0, "t6c");
        check("t6_s", 32'(bus.acoes[2]), 32'd1);

        // Host inhibit: clock held low mid-frame
        send_bits(8'h1D, 0, 0, 3, 0);
        bus.ps2_clk = 1'b0;
        repeat (TMO + 200) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (GAP) @(negedge clk);
        model_abort();
        check_all("t7");

        // Bad stop bit
        xmit(8'h1D, 0, 1, 0, "t8");

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            k   = keys[$urandom_range(0, 11)];
            rb  = 8'($urandom_range(0, 255));
            if (sel < 6) begin
                if (k[8]) xmit(8'hE0, 0, 0, 0, "rnd_e0");
                if ($urandom_range(0, 1) == 1) xmit(8'hF0, 0, 0, 0, "rnd_f0");
                xmit(k[7:0], 0, 0, 0, "rnd_key");
            end else if (sel < 8) begin
                xmit(rb, 0, 0, 0, "rnd_byte");
            end else if (sel == 8) begin
                xmit(rb, 1, 0, 0, "rnd_par");
            end else begin
                xmit(rb, 0, 1, 0, "rnd_stop");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
